// File: rtl/bus_pkg.sv
// Shared definitions for the multiplexed address/data bus cycle controller:
// cycle-type and state enums, the s1/s0 status encodings, and cycle-type
// classification helpers.
package bus_pkg;

  typedef enum logic [2:0] {
    CYC_FETCH = 3'd0,
    CYC_MRD   = 3'd1,
    CYC_MWR   = 3'd2,
    CYC_IORD  = 3'd3,
    CYC_IOWR  = 3'd4,
    CYC_HALT  = 3'd5
  } cyc_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_TW   = 3'd3,
    ST_T3   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  // {s1, s0} status encodings presented for the whole bus cycle
  localparam logic [1:0] SS_FETCH = 2'b11;
  localparam logic [1:0] SS_MRD   = 2'b10;
  localparam logic [1:0] SS_MWR   = 2'b01;
  localparam logic [1:0] SS_IORD  = 2'b10;
  localparam logic [1:0] SS_IOWR  = 2'b01;
  localparam logic [1:0] SS_HALT  = 2'b00;

  function automatic logic [1:0] status_of(input cyc_e t);
    case (t)
      CYC_FETCH: return SS_FETCH;
      CYC_MRD:   return SS_MRD;
      CYC_MWR:   return SS_MWR;
      CYC_IORD:  return SS_IORD;
      CYC_IOWR:  return SS_IOWR;
      default:   return SS_HALT;
    endcase
  endfunction

  function automatic logic is_read(input cyc_e t);
    return (t == CYC_FETCH) || (t == CYC_MRD) || (t == CYC_IORD);
  endfunction

  function automatic logic is_write(input cyc_e t);
    return (t == CYC_MWR) || (t == CYC_IOWR);
  endfunction

  function automatic logic is_io(input cyc_e t);
    return (t == CYC_IORD) || (t == CYC_IOWR);
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Counts consecutive wait-state (TW) cycles and flags the cycle in which
// the TIMEOUT_CYC-th consecutive wait state is being spent.
module bus_wait_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clock,
  input  logic reset_in_n,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count while waiting (saturating), restart whenever the wait ends
  always_comb begin
    cnt_d = '0;
    if (count_en) begin
      cnt_d = (cnt_q == CW'(TIMEOUT_CYC)) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clock or negedge reset_in_n) begin
    if (!reset_in_n) cnt_q <= '0;
    else             cnt_q <= cnt_d;
  end

  assign expired = count_en && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/bus_cycle_ctrl.sv
// Bus cycle controller for a multiplexed low-address/data bus (T1/T2/TW/T3
// cycles with ALE, RD#/WR#, IO/M# and s1/s0 status), with burst support.
// Optional feature macro: BUS_TIMEOUT_EN aborts a cycle that waits in TW for
// TIMEOUT_CYC consecutive cycles with an error response.
module bus_cycle_ctrl
  import bus_pkg::*;
#(
  parameter int AW          = 16,
  parameter int DW          = 8,
  parameter int MAX_BURST   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clock,
  input  logic                      reset_in_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [2:0]                req_type,
  input  logic [AW-1:0]             req_addr,
  input  logic [DW*MAX_BURST-1:0]   req_wdata,
  input  logic [$clog2(MAX_BURST):0] req_len,
  output logic                      rsp_valid,
  output logic [DW-1:0]             rsp_data,
  output logic                      rsp_last,
  output logic                      rsp_err,
  output logic                      busy,
  input  logic                      resume,
  inout  wire  [DW-1:0]             ad,
  output logic [AW-DW-1:0]          a_hi,
  output logic                      ale,
  output logic                      rd_n,
  output logic                      wr_n,
  output logic                      io_m_n,
  output logic                      s0,
  output logic                      s1,
  input  logic                      ready
);

  localparam int LW = $clog2(MAX_BURST) + 1;
  localparam int HW = AW - DW;

  if (AW <= DW) begin : g_chk_aw
    $error("bus_cycle_ctrl: AW must exceed DW");
  end
  if (TIMEOUT_CYC < 1) begin : g_chk_timeout
    $error("bus_cycle_ctrl: TIMEOUT_CYC must be at least 1");
  end

  // Zero length means one beat, oversize lengths clamp, IO is always single-beat
  function automatic logic [LW-1:0] norm_len(input logic [LW-1:0] len, input logic io);
    if (io || (len == '0))          return LW'(1);
    else if (len > LW'(MAX_BURST))  return LW'(MAX_BURST);
    else                            return len;
  endfunction

  state_e                  state_q, state_d;
  cyc_e                    type_q, type_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [DW*MAX_BURST-1:0] wdata_q, wdata_d;
  logic [LW-1:0]           left_q, left_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_last_q, rsp_last_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [DW-1:0]           rsp_data_q, rsp_data_d;
  logic                    timeout;
  cyc_e                    req_cyc;

  assign req_cyc = cyc_e'(req_type);

`ifdef BUS_TIMEOUT_EN
  bus_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
    .clock      (clock),
    .reset_in_n (reset_in_n),
    .count_en   (state_q == ST_TW),
    .expired    (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Next-state, beat bookkeeping and response generation
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    left_d      = left_q;
    rsp_valid_d = 1'b0;
    rsp_last_d  = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          type_d  = req_cyc;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          left_d  = norm_len(req_len, is_io(req_cyc));
          state_d = (req_cyc == CYC_HALT) ? ST_HALT : ST_T1;
        end
      end
      ST_T1: state_d = ST_T2;
      ST_T2: state_d = ready ? ST_T3 : ST_TW;
      ST_TW: begin
        if (ready) begin
          state_d = ST_T3;
        end else if (timeout) begin
          // Abandon this and all remaining beats with an error response
          state_d     = ST_IDLE;
          left_d      = '0;
          rsp_valid_d = 1'b1;
          rsp_last_d  = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end
      end
      ST_T3: begin
        rsp_valid_d = 1'b1;
        rsp_last_d  = (left_q == LW'(1));
        rsp_data_d  = is_read(type_q) ? ad : '0;
        left_d      = left_q - 1'b1;
        addr_d      = addr_q + 1'b1;
        wdata_d     = wdata_q >> DW;
        state_d     = (left_q == LW'(1)) ? ST_IDLE : ST_T1;
      end
      ST_HALT: if (resume) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and response registers
  always_ff @(posedge clock or negedge reset_in_n) begin
    if (!reset_in_n) begin
      state_q     <= ST_IDLE;
      left_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      left_q      <= left_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Request payload registers; only meaningful outside IDLE
  always_ff @(posedge clock) begin
    type_q  <= type_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  logic          in_cycle, strobe_ph, ad_oe;
  logic [1:0]    status;
  logic [DW-1:0] addr_lo, ad_out;
  logic [HW-1:0] addr_hi;

  assign in_cycle  = (state_q == ST_T1) || (state_q == ST_T2) ||
                     (state_q == ST_TW) || (state_q == ST_T3);
  assign strobe_ph = (state_q == ST_T2) || (state_q == ST_TW);

  // IO cycles put the 8-bit port number on both address halves
  assign addr_lo = is_io(type_q) ? DW'(addr_q[7:0]) : addr_q[DW-1:0];
  assign addr_hi = is_io(type_q) ? HW'(addr_q[7:0]) : addr_q[AW-1:DW];

  assign status  = in_cycle ? status_of(type_q) : 2'b00;
  assign s1      = status[1];
  assign s0      = status[0];
  assign io_m_n  = in_cycle && is_io(type_q);
  assign ale     = (state_q == ST_T1);
  assign a_hi    = in_cycle ? addr_hi : '0;
  assign rd_n    = !(is_read(type_q) && (strobe_ph || (state_q == ST_T3)));
  assign wr_n    = !(is_write(type_q) && strobe_ph);

  assign ad_oe   = (state_q == ST_T1) ||
                   (is_write(type_q) && (strobe_ph || (state_q == ST_T3)));
  assign ad_out  = (state_q == ST_T1) ? addr_lo : wdata_q[DW-1:0];
  assign ad      = ad_oe ? ad_out : {DW{1'bz}};

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl (default parameters, TIMEOUT_CYC=4).
module tb_bus_cycle_ctrl;
  import bus_pkg::*;

  logic        clock = 1'b0;
  logic        reset_in_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_type;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_len;
  logic        rsp_valid, rsp_last, rsp_err, busy, resume;
  logic [7:0]  rsp_data;
  wire  [7:0]  ad;
  logic [7:0]  a_hi;
  logic        ale, rd_n, wr_n, io_m_n, s0, s1, ready;
  logic [7:0]  bus_drv;

  int total = 0;
  int bad   = 0;

  bus_cycle_ctrl #(.AW(16), .DW(8), .MAX_BURST(4), .TIMEOUT_CYC(4)) dut (
    .clock(clock), .reset_in_n(reset_in_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .busy(busy), .resume(resume), .ad(ad), .a_hi(a_hi), .ale(ale), .rd_n(rd_n),
    .wr_n(wr_n), .io_m_n(io_m_n), .s0(s0), .s1(s1), .ready(ready)
  );

  // Memory/IO side: returns read data while the read strobe is low;
  // an undriven bus floats high through the pull-ups.
  assign ad = (!rd_n) ? bus_drv : 8'bz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (ad[i]);
  end

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic accept(input logic [2:0] t, input logic [15:0] a,
                        input logic [2:0] len, input logic [31:0] wd);
    req_type  = t;
    req_addr  = a;
    req_len   = len;
    req_wdata = wd;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_in_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if ({rd_n, wr_n, ale, io_m_n, s1, s0, rsp_valid, rsp_last, rsp_err, busy} !== 10'b1100000000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=1100000000",
               {rd_n, wr_n, ale, io_m_n, s1, s0, rsp_valid, rsp_last, rsp_err, busy});
    end
    total++;
    if (a_hi !== 8'h00 || rsp_data !== 8'h00) begin
      bad++; $display("FAIL reset_data a_hi=%h rsp_data=%h want 00 00", a_hi, rsp_data);
    end
    total++;
    if (ad !== 8'hFF) begin bad++; $display("FAIL reset_ad_released got=%h want=FF", ad); end
    reset_in_n = 1'b1;
    tick();
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_mrd;
    ready = 1'b1; bus_drv = 8'h5A;
    accept(CYC_MRD, 16'h1234, 3'd1, 32'h0);
    // T1
    total++;
    if ({ale, s1, s0, io_m_n, rd_n, wr_n, busy, req_ready} !== 8'b11001110) begin
      bad++; $display("FAIL mrd_t1_ctrl got=%b want=11001110", {ale, s1, s0, io_m_n, rd_n, wr_n, busy, req_ready});
    end
    total++;
    if (ad !== 8'h34 || a_hi !== 8'h12) begin
      bad++; $display("FAIL mrd_t1_addr ad=%h a_hi=%h want 34 12", ad, a_hi);
    end
    tick(); // T2
    total++;
    if ({ale, rd_n, wr_n, s1, s0, rsp_valid} !== 6'b001100) begin
      bad++; $display("FAIL mrd_t2 got=%b want=001100", {ale, rd_n, wr_n, s1, s0, rsp_valid});
    end
    tick(); // T3
    total++;
    if ({rd_n, rsp_valid} !== 2'b00) begin bad++; $display("FAIL mrd_t3 got=%b want=00", {rd_n, rsp_valid}); end
    tick(); // response cycle
    total++;
    if ({rsp_valid, rsp_last, rsp_err, rd_n, busy} !== 5'b11010 || rsp_data !== 8'h5A) begin
      bad++; $display("FAIL mrd_rsp flags=%b data=%h want 11010 5A", {rsp_valid, rsp_last, rsp_err, rd_n, busy}, rsp_data);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mrd_rsp_pulse got=%b want=0", rsp_valid); end
  endtask

  task automatic test_mwr;
    logic [7:0] exp_lo [3] = '{8'hFE, 8'hFF, 8'h00};
    logic [7:0] exp_hi [3] = '{8'hFF, 8'hFF, 8'h00};
    logic [7:0] exp_d  [3] = '{8'h11, 8'h22, 8'h33};
    int wr_low;
    accept(CYC_MWR, 16'hFFFE, 3'd3, 32'h0033_2211);
    for (int k = 0; k < 3; k++) begin
      // T1 of beat k (carries the previous beat's response)
      total++;
      if ({ale, s1, s0, wr_n, rd_n} !== 5'b10111 || ad !== exp_lo[k] || a_hi !== exp_hi[k]) begin
        bad++; $display("FAIL mwr_t1_beat%0d ctrl=%b ad=%h a_hi=%h want 10111 %h %h",
                        k, {ale, s1, s0, wr_n, rd_n}, ad, a_hi, exp_lo[k], exp_hi[k]);
      end
      if (k > 0) begin
        total++;
        if ({rsp_valid, rsp_last} !== 2'b10 || rsp_data !== 8'h00) begin
          bad++; $display("FAIL mwr_rsp_beat%0d got=%b data=%h want 10 00", k - 1, {rsp_valid, rsp_last}, rsp_data);
        end
      end
      wr_low = 0;
      ready = 1'b0;
      tick(); // T2
      if (wr_n === 1'b0) wr_low++;
      total++;
      if (ad !== exp_d[k]) begin bad++; $display("FAIL mwr_data_beat%0d got=%h want=%h", k, ad, exp_d[k]); end
      tick(); // TW
      if (wr_n === 1'b0) wr_low++;
      ready = 1'b1;
      tick(); // T3
      if (wr_n === 1'b0) wr_low++;
      total++;
      if (wr_low !== 2) begin bad++; $display("FAIL mwr_wr_low_beat%0d got=%0d want=2", k, wr_low); end
      tick();
    end
    total++;
    if ({rsp_valid, rsp_last, rsp_err, busy, req_ready} !== 5'b11001 || rsp_data !== 8'h00) begin
      bad++; $display("FAIL mwr_last_rsp got=%b data=%h want 11001 00", {rsp_valid, rsp_last, rsp_err, busy, req_ready}, rsp_data);
    end
  endtask

  task automatic test_fetch_wait;
    int n_tw;
`ifdef BUS_TIMEOUT_EN
    n_tw = 4;
`else
    n_tw = 5;
`endif
    bus_drv = 8'hC3;
    accept(CYC_FETCH, 16'h0100, 3'd1, 32'h0);
    ready = 1'b0;
    total++;
    if ({s1, s0, ale} !== 3'b111) begin bad++; $display("FAIL fetch_t1 got=%b want=111", {s1, s0, ale}); end
    tick(); // T2
    for (int i = 0; i < n_tw; i++) begin
      tick(); // TW i+1
      total++;
      if ({rd_n, rsp_valid, busy, s1, s0} !== 5'b00111) begin
        bad++; $display("FAIL fetch_tw%0d got=%b want=00111", i + 1, {rd_n, rsp_valid, busy, s1, s0});
      end
    end
`ifdef BUS_TIMEOUT_EN
    tick();
    total++;
    if ({rsp_valid, rsp_err, rsp_last, rd_n, busy} !== 5'b11110) begin
      bad++; $display("FAIL fetch_timeout got=%b want=11110", {rsp_valid, rsp_err, rsp_last, rd_n, busy});
    end
    ready = 1'b1;
`else
    ready = 1'b1;
    tick(); // T3
    total++;
    if ({rd_n, rsp_valid} !== 2'b00) begin bad++; $display("FAIL fetch_t3 got=%b want=00", {rd_n, rsp_valid}); end
    tick();
    total++;
    if ({rsp_valid, rsp_last, rsp_err} !== 3'b110 || rsp_data !== 8'hC3) begin
      bad++; $display("FAIL fetch_rsp got=%b data=%h want 110 C3", {rsp_valid, rsp_last, rsp_err}, rsp_data);
    end
`endif
    tick();
  endtask

  task automatic test_io;
    ready = 1'b1; bus_drv = 8'h99;
    accept(CYC_IORD, 16'hAB42, 3'd3, 32'h0);
    total++;
    if ({ale, io_m_n, s1, s0} !== 4'b1110 || ad !== 8'h42 || a_hi !== 8'h42) begin
      bad++; $display("FAIL io_t1 ctrl=%b ad=%h a_hi=%h want 1110 42 42", {ale, io_m_n, s1, s0}, ad, a_hi);
    end
    tick(); // T2
    total++;
    if ({rd_n, io_m_n} !== 2'b01) begin bad++; $display("FAIL io_t2 got=%b want=01", {rd_n, io_m_n}); end
    tick(); // T3
    tick();
    total++;
    if ({rsp_valid, rsp_last, busy} !== 3'b110 || rsp_data !== 8'h99) begin
      bad++; $display("FAIL io_rsp got=%b data=%h want 110 99", {rsp_valid, rsp_last, busy}, rsp_data);
    end
    tick();
    total++;
    if ({busy, ale, rsp_valid, io_m_n} !== 4'b0000) begin
      bad++; $display("FAIL io_single_beat got=%b want=0000", {busy, ale, rsp_valid, io_m_n});
    end
  endtask

  task automatic test_len_norm;
    logic [2:0] lens [2] = '{3'd0, 3'd7};
    int         exp_n [2] = '{1, 4};
    int pulses;
    bit got_last;
    ready = 1'b1; bus_drv = 8'h77;
    for (int c = 0; c < 2; c++) begin
      pulses = 0; got_last = 0;
      accept(CYC_MRD, 16'h3000, lens[c], 32'h0);
      for (int cyc = 0; cyc < 40 && !got_last; cyc++) begin
        tick();
        if (rsp_valid === 1'b1) begin
          pulses++;
          if (rsp_last === 1'b1) got_last = 1;
        end
      end
      total++;
      if (!got_last) begin bad++; $display("FAIL len%0d_no_last got=0 want=1", lens[c]); end
      total++;
      if (pulses !== exp_n[c]) begin bad++; $display("FAIL len%0d_beats got=%0d want=%0d", lens[c], pulses, exp_n[c]); end
      tick();
    end
  endtask

  task automatic test_reset_mid_write;
    bit seen_rsp;
    accept(CYC_MWR, 16'h2000, 3'd2, 32'h0000_665C);
    ready = 1'b0;
    tick(); // T2
    tick(); // TW
    total++;
    if (wr_n !== 1'b0 || ad !== 8'h5C) begin bad++; $display("FAIL rst_mid_pre wr_n=%b ad=%h want 0 5C", wr_n, ad); end
    reset_in_n = 1'b0;
    #1;
    total++;
    if ({wr_n, rd_n, ale, busy, rsp_valid} !== 5'b11000 || ad !== 8'hFF) begin
      bad++; $display("FAIL rst_mid_async ctrl=%b ad=%h want 11000 FF", {wr_n, rd_n, ale, busy, rsp_valid}, ad);
    end
    tick();
    reset_in_n = 1'b1;
    ready = 1'b1;
    seen_rsp = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid !== 1'b0) seen_rsp = 1;
    end
    total++;
    if (seen_rsp) begin bad++; $display("FAIL rst_mid_no_rsp got=1 want=0"); end
    total++;
    if ({req_ready, busy, wr_n} !== 3'b101) begin
      bad++; $display("FAIL rst_mid_after got=%b want=101", {req_ready, busy, wr_n});
    end
  endtask

  task automatic test_halt;
    accept(CYC_HALT, 16'h0000, 3'd1, 32'h0);
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({busy, req_ready, rd_n, wr_n, s1, s0, ale} !== 7'b1011000 || ad !== 8'hFF) begin
        bad++; $display("FAIL halt_cyc%0d ctrl=%b ad=%h want 1011000 FF", i + 1,
                        {busy, req_ready, rd_n, wr_n, s1, s0, ale}, ad);
      end
      if (i < 9) tick();
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    total++;
    if ({busy, req_ready, rsp_valid} !== 3'b010) begin
      bad++; $display("FAIL halt_resume got=%b want=010", {busy, req_ready, rsp_valid});
    end
  endtask

  initial begin
    reset_in_n = 1'b0;
    req_valid  = 1'b0;
    req_type   = 3'd0;
    req_addr   = 16'h0;
    req_wdata  = 32'h0;
    req_len    = 3'd0;
    resume     = 1'b0;
    ready      = 1'b1;
    bus_drv    = 8'h00;
    test_reset();
    test_mrd();
    test_mwr();
    test_fetch_wait();
    test_io();
    test_len_norm();
    test_reset_mid_write();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_cycle_ctrl.md
BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

Interface
REQ-001 SHALL have parameter AW, default 16, meaning the address width (AW > DW).
REQ-002 SHALL have parameter DW, default 8, meaning the data width and the width of the multiplexed low-address/data bus.
REQ-003 SHALL have parameter MAX_BURST, default 4, meaning the maximum number of beats per request.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 16, meaning the number of wait cycles before a cycle is aborted (used only with the macro).
REQ-005 SHALL have port clock, input, 1 bit; the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_in_n, input, 1 bit; reset is asynchronous and active-low.
REQ-007 SHALL have req_valid in 1, req_ready out 1, req_type in 3 (FETCH, MRD, MWR, IORD, IOWR, HALT), req_addr in AW, req_wdata in DW*MAX_BURST, req_len in $clog2(MAX_BURST)+1.
REQ-008 SHALL have rsp_valid out 1, rsp_data out DW, rsp_last out 1, rsp_err out 1, busy out 1, resume in 1.
REQ-009 SHALL have bus ports ad inout DW, a_hi out AW-DW, ale out 1, rd_n out 1, wr_n out 1, io_m_n out 1, s0 out 1, s1 out 1, ready in 1.

Function
REQ-010 SHALL implement states IDLE, T1, T2, TW, T3, HALT.
REQ-011 SHALL drive req_ready high only in IDLE; a request is accepted on the rising edge where req_valid and req_ready are both high.
REQ-012 SHALL go from IDLE to T1 on acceptance (HALT type: go to HALT); T1->T2; T2->T3 if ready=1, else T2->TW; TW->T3 when ready=1; T3->T1 if beats remain, else T3->IDLE.
REQ-013 SHALL assert ale only during T1, with address bits [DW-1:0] on ad and bits [AW-1:DW] on a_hi.
REQ-014 SHALL assert rd_n low in T2/TW/T3 for reads and wr_n low in T2/TW for writes; at most one strobe is low at any time.
REQ-015 SHALL drive ad only during T1, and during T2/TW/T3 of writes; otherwise ad is high-impedance.
REQ-016 SHALL hold status constant from T1 through T3: FETCH s1s0=11, MRD 10, MWR 01, HALT 00; io_m_n=1 for IORD/IOWR, else 0.
REQ-017 SHALL sample read data from ad on the T3 rising edge and pulse rsp_valid for exactly one cycle after it; rsp_last=1 on the final beat.
REQ-018 SHALL pulse rsp_valid after T3 of each write beat with rsp_data=0.
REQ-019 SHALL give a single-beat read with ready=1 a latency of 4 cycles from acceptance to rsp_valid.
REQ-020 SHALL present beat k at req_addr+k modulo 2^AW (wrap from FFFF to 0000) with write data req_wdata[k*DW +: DW].
REQ-021 SHALL treat req_len=0 as 1 and req_len>MAX_BURST as MAX_BURST.
REQ-022 SHALL force IO requests to 1 beat and drive req_addr[7:0] on both the ad and a_hi low byte.
REQ-023 SHALL, in HALT, keep both strobes high and ad at high-impedance; a resume pulse returns it to IDLE.
REQ-024 SHALL drive busy high in every state except IDLE.

Reset
REQ-025 SHALL, while reset_in_n=0, force: state IDLE, rd_n=1, wr_n=1, ale=0, io_m_n=0, s1s0=00, a_hi=0, ad high-impedance, rsp_valid=0, rsp_data=0, rsp_last=0, rsp_err=0, busy=0.
REQ-026 SHALL abandon an in-progress cycle on reset without producing a response; after release, req_ready=1.

Configuration
REQ-027 SHALL, with BUS_TIMEOUT_EN defined, count consecutive TW cycles; at TIMEOUT_CYC it deasserts the strobes, pulses rsp_valid with rsp_err=1 and rsp_last=1, drops the remaining beats, and goes to IDLE.
REQ-028 SHALL, without BUS_TIMEOUT_EN, wait in TW indefinitely and tie rsp_err to 0.

Structure
REQ-029 SHALL place the cycle-type enum, the state enum and the s1/s0 encoding constants in the shared package bus_pkg.
REQ-030 SHALL use one sub-module, bus_wait_timer (the TW counter), instantiated only under BUS_TIMEOUT_EN.

Verification
REQ-031 SHALL cover: MRD at 0x1234, len 1, ready=1, bus returns 0x5A -> ale in T1 with ad=0x34 and a_hi=0x12, s1s0=10, rsp_data=0x5A with rsp_last=1 four cycles after acceptance.
REQ-032 SHALL cover: MWR at 0xFFFE, len 3, data 11,22,33 -> writes go to FFFE, FFFF, 0000; wr_n low twice per beat; three rsp_valid pulses, the last with rsp_last=1.
REQ-033 SHALL cover: FETCH with ready held low 5 cycles -> 5 TW cycles, rd_n stays low, then rsp_valid; with the macro and TIMEOUT_CYC=4, an error response instead.
REQ-034 SHALL cover: IORD at port 0x42, len 3 -> one beat, ad=0x42 and a_hi=0x0042, io_m_n=1.
REQ-035 SHALL cover: reset_in_n low during TW of a write -> wr_n=1 and ad high-impedance immediately, no rsp_valid, req_ready=1 after release.
REQ-036 SHALL cover: HALT request, then resume after 10 cycles -> s1s0=00, strobes high for 10 cycles, then IDLE.
